// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave core: FSM encoding, data width,
// synchronizer depth and the bit-ordering helper.
package spi_pkg;

    localparam int DATA_W     = 8;
    localparam int SYNC_DEPTH = 2;
    localparam int CNT_W      = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

    // Map a serial bit position (0 = first bit on the wire) to a byte index.
    function automatic logic [CNT_W-1:0] bit_index(input logic [CNT_W-1:0] pos,
                                                   input logic             lsb_first);
        return lsb_first ? pos : (CNT_W'(DATA_W - 1) - pos);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, plus rise/fall detection
// against a one-cycle-delayed copy of the synchronized value.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic PCLK,
    input  logic PRESET_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_reg;
    logic                  dly_reg;

    // Synchronizer chain and edge-detect delay stage.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            sync_reg <= {SYNC_DEPTH{RESET_VAL}};
            dly_reg  <= RESET_VAL;
        end else begin
            sync_reg <= {sync_reg[SYNC_DEPTH-2:0], pin};
            dly_reg  <= sync_reg[SYNC_DEPTH-1];
        end
    end

    assign sync = sync_reg[SYNC_DEPTH-1];
    assign rise = sync_reg[SYNC_DEPTH-1] & ~dly_reg;
    assign fall = ~sync_reg[SYNC_DEPTH-1] & dly_reg;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave core: byte-wide full-duplex shifter running entirely on PCLK,
// oversampling ss/sclk/mosi through synchronizers.
// Optional build macro SPI_SLAVE_LSBFE_EN enables LSB-first operation via
// lsbfe_i; without it the core is always MSB first.
module spi_slave_core
    import spi_pkg::*;
(
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              spe_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsbfe_i,
    input  logic              ss_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              overrun_o
);

    // Pin order in the synchronizer bank: [2]=ss, [1]=sclk, [0]=mosi.
    localparam logic [2:0] SYNC_RESET = 3'b100;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [2:0] pins;
    logic [2:0] sync_vec;
    logic [2:0] rise_vec;
    logic [2:0] fall_vec;

    assign pins = {ss_i, sclk_i, mosi_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync_edge #(
                .RESET_VAL(SYNC_RESET[gi])
            ) u_sync (
                .PCLK    (PCLK),
                .PRESET_n(PRESET_n),
                .pin     (pins[gi]),
                .sync    (sync_vec[gi]),
                .rise    (rise_vec[gi]),
                .fall    (fall_vec[gi])
            );
        end
    endgenerate

    logic ss_sync, ss_fall, sclk_rise, sclk_fall, mosi_sync;
    logic unused_sync;

    assign ss_sync     = sync_vec[2];
    assign ss_fall     = fall_vec[2];
    assign sclk_rise   = rise_vec[1];
    assign sclk_fall   = fall_vec[1];
    assign mosi_sync   = sync_vec[0];
    // ss rise is implied by ss_sync being high; sclk level and mosi edges are not needed.
    assign unused_sync = ^{rise_vec[2], sync_vec[1], rise_vec[0], fall_vec[0]};

    logic lsb_sel;
`ifdef SPI_SLAVE_LSBFE_EN
    assign lsb_sel = lsbfe_i;
`else
    logic unused_lsbfe;
    assign lsb_sel      = 1'b0;
    assign unused_lsbfe = lsbfe_i;
`endif

    spi_state_e        state_reg, state_next;
    logic              cpol_reg, cpha_reg, lsb_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic [DATA_W-1:0] hold_reg;
    logic              tx_ready_reg;
    logic              miso_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg;
    logic              overrun_reg;

    logic              lead_edge, trail_edge, sample_edge, drive_edge;
    logic              deselect, byte_done, load_xfer, load_accept;
    logic [DATA_W-1:0] load_byte;
    logic [DATA_W-1:0] rx_assembled;

    // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
    assign lead_edge   = cpol_reg ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_reg ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    // With cpha=0 the first bit is presented by LOAD, so the trailing edge
    // that follows the last sample of a byte must not advance the output.
    assign drive_edge  = cpha_reg ? lead_edge : (trail_edge && (cnt_reg != '0));

    assign deselect    = ss_sync || !spe_i;
    assign byte_done   = (state_reg == SHIFT) && sample_edge && (cnt_reg == LAST_BIT);
    assign load_xfer   = (state_reg == LOAD) && !deselect;
    assign load_byte   = tx_ready_reg ? '0 : hold_reg;
    // A load coinciding with LOAD is taken after the old value moves out.
    assign load_accept = tx_load_i && (tx_ready_reg || load_xfer);

    // Byte as it will look once the current mosi bit is merged in.
    always_comb begin
        rx_assembled = rx_shift_reg;
        rx_assembled[bit_index(cnt_reg, lsb_reg)] = mosi_sync;
    end

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) state_reg <= IDLE;
        else           state_reg <= state_next;
    end

    // FSM next-state; deselect overrides everything.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ss_fall && spe_i) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (byte_done) state_next = LOAD;
            default: state_next = IDLE;
        endcase
        if (deselect) state_next = IDLE;
    end

    // Transfer mode is frozen at the start of each selection.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cpol_reg <= 1'b0;
            cpha_reg <= 1'b0;
            lsb_reg  <= 1'b0;
        end else if (state_reg == IDLE && state_next == LOAD) begin
            cpol_reg <= cpol_i;
            cpha_reg <= cpha_i;
            lsb_reg  <= lsb_sel;
        end
    end

    // Transmit holding register, ready flag and sticky overrun.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            hold_reg     <= '0;
            tx_ready_reg <= 1'b1;
            overrun_reg  <= 1'b0;
        end else begin
            if (load_accept) begin
                hold_reg     <= tx_data_i;
                tx_ready_reg <= 1'b0;
            end else if (load_xfer) begin
                tx_ready_reg <= 1'b1;
            end
            if (load_xfer && tx_ready_reg) overrun_reg <= 1'b1;
        end
    end

    // Shift datapath: bit counter, serial in/out and received-byte strobe.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cnt_reg      <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            miso_reg     <= 1'b0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (state_reg == IDLE || deselect) begin
                cnt_reg  <= '0;
                miso_reg <= 1'b0;
            end else if (load_xfer) begin
                tx_shift_reg <= load_byte;
                cnt_reg      <= '0;
                if (!cpha_reg) miso_reg <= load_byte[bit_index('0, lsb_reg)];
            end else if (state_reg == SHIFT) begin
                if (sample_edge) begin
                    rx_shift_reg <= rx_assembled;
                    cnt_reg      <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        rx_data_reg  <= rx_assembled;
                        rx_valid_reg <= 1'b1;
                    end
                end
                if (drive_edge) miso_reg <= tx_shift_reg[bit_index(cnt_reg, lsb_reg)];
            end
        end
    end

    assign miso_o     = miso_reg;
    assign tx_ready_o = tx_ready_reg;
    assign rx_data_o  = rx_data_reg;
    assign rx_valid_o = rx_valid_reg;
    assign overrun_o  = overrun_reg;

endmodule
